// File: rtl/spram_line_reader.sv
// spram_line_reader
//   Read-side front end for the rgb_panel SPRAM framebuffer. Each accepted
//   line request streams N_COLS = 2**LOG_COLS pixels of one row to the panel
//   shifter. A 2-entry buffer absorbs the SPRAM read latency and downstream
//   backpressure. The host write port owns the SPRAM on every cycle the
//   reader does not issue a read.
//   Optional feature: define SPRAM_LINE_READER_DOUBLE_BUFFER_EN to split the
//   SPRAM into two banks on address bit 13 (front bank read, back bank written)
//   with a swap applied at the start of row 0.
//
// Handshakes:
//   px_*  : a pixel transfers on a rising edge where px_valid && px_ready.
//           While px_valid=1 and px_ready=0, px_data/px_valid/px_last hold.
//   wr_*  : a host write transfers on a rising edge where wr_valid && wr_ready.
//           wr_ready is combinational and is low only on read-issue cycles.
module spram_line_reader #(
    parameter int LOG_COLS = 6,
    parameter int LOG_ROWS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                line_start,
    input  logic [LOG_ROWS-1:0] line_row,
    output logic                line_busy,
    output logic                line_done,
    output logic [15:0]         px_data,
    output logic                px_valid,
    input  logic                px_ready,
    output logic                px_last,
    input  logic                wr_valid,
    input  logic [13:0]         wr_addr,
    input  logic [15:0]         wr_data,
    input  logic [3:0]          wr_mask,
    output logic                wr_ready,
    output logic [13:0]         ram_addr,
    output logic [15:0]         ram_din,
    output logic [3:0]          ram_mask,
    output logic                ram_wren,
    output logic                ram_cs,
    input  logic [15:0]         ram_dout,
`ifdef SPRAM_LINE_READER_DOUBLE_BUFFER_EN
    input  logic                fb_swap,
    output logic                fb_front,
`endif
    output logic [1:0]          dbg_state
);

    localparam int PAD = 14 - LOG_ROWS - LOG_COLS;
    localparam logic [LOG_COLS-1:0] COL_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic [LOG_ROWS-1:0] row_q;
    logic [LOG_COLS-1:0] col_q;
    logic                busy_q;
    logic                done_q;
    logic                inflight;
    logic                inflight_last;

    // Two-entry pixel buffer; entry 0 is the head presented downstream.
    logic                v0, v1, l0, l1;
    logic [15:0]         d0, d1;
    logic                n_v0, n_v1, n_l0, n_l1;
    logic [15:0]         n_d0, n_d1;

    logic                pop;
    logic                issue;
    logic                last_hs;
    logic [1:0]          occ_sum;
    logic [13:0]         rd_addr;
    logic [13:0]         wr_addr_eff;
    logic                front_q;

    // Read-issue decision: buffered words plus the word in flight never exceed 2.
    always_comb begin
        pop     = v0 & px_ready;
        last_hs = pop & l0;
        occ_sum = {1'b0, v0} + {1'b0, v1} + {1'b0, inflight};
        issue   = (state == S_RUN) && ((occ_sum < 2'd2) || ((occ_sum == 2'd2) && pop));
    end

    // Address formation for the read side and bank steering of host writes.
    always_comb begin
        rd_addr     = {{PAD{1'b0}}, row_q, col_q};
        wr_addr_eff = wr_addr;
`ifdef SPRAM_LINE_READER_DOUBLE_BUFFER_EN
        rd_addr[13]     = front_q;
        wr_addr_eff[13] = ~front_q;
`endif
    end

    // SPRAM port sharing: a read issue takes the port, otherwise the host writes.
    always_comb begin
        wr_ready = ~issue;
        ram_addr = issue ? rd_addr : wr_addr_eff;
        ram_din  = wr_data;
        ram_mask = wr_mask;
        ram_wren = ~issue & wr_valid;
        ram_cs   = 1'b1;
    end

    // Line sequencing: request latch, column issue counter, completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (col_q == COL_MAX);
            case (state)
                S_IDLE: begin
                    if (line_start) begin
                        state  <= S_RUN;
                        row_q  <= line_row;
                        col_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        col_q <= col_q + 1'b1;
                        if (col_q == COL_MAX) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_hs) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Next buffer contents: pop shifts entry 1 forward, a returning read fills the first free slot.
    always_comb begin
        n_v0 = v0;
        n_v1 = v1;
        n_d0 = d0;
        n_d1 = d1;
        n_l0 = l0;
        n_l1 = l1;
        if (pop) begin
            n_v0 = v1;
            n_d0 = d1;
            n_l0 = l1;
            n_v1 = 1'b0;
            n_l1 = 1'b0;
        end
        if (inflight) begin
            if (!n_v0) begin
                n_v0 = 1'b1;
                n_d0 = ram_dout;
                n_l0 = inflight_last;
            end else begin
                n_v1 = 1'b1;
                n_d1 = ram_dout;
                n_l1 = inflight_last;
            end
        end
    end

    // Buffer registers; SPRAM data is only taken on the edge after a read issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            l0 <= 1'b0;
            l1 <= 1'b0;
            d0 <= '0;
            d1 <= '0;
        end else begin
            v0 <= n_v0;
            v1 <= n_v1;
            l0 <= n_l0;
            l1 <= n_l1;
            d0 <= n_d0;
            d1 <= n_d1;
        end
    end

`ifdef SPRAM_LINE_READER_DOUBLE_BUFFER_EN
    logic swap_pend;
    logic swap_apply;

    assign swap_apply = (state == S_IDLE) && line_start && (line_row == '0) && swap_pend;

    // Bank swap: requests collapse into one pending flag, applied at the start of row 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_pend <= 1'b0;
            front_q   <= 1'b0;
        end else begin
            swap_pend <= (swap_pend & ~swap_apply) | fb_swap;
            front_q   <= front_q ^ swap_apply;
        end
    end

    assign fb_front = front_q;
`else
    assign front_q = 1'b0;
`endif

    assign line_busy = busy_q;
    assign line_done = done_q;
    assign px_valid  = v0;
    assign px_data   = d0;
    assign px_last   = l0;
    assign dbg_state = state;

endmodule
